// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier: FSM state
// encoding, Booth recode operations and the accumulator width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

  localparam int DEFAULT_N = 6;
  localparam int ACC_W     = 2 * DEFAULT_N + 1;

  function automatic int acc_width(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/booth_cla_adder.sv
// Accumulator carry-lookahead adder: 4-bit groups with group-level lookahead
// between them. The carry-in is 0 and the carry out of the MSB is not produced.
module booth_cla_adder #(
  parameter int W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] cg;

  // Group carries come from group generate/propagate; bit carries are then
  // resolved inside each group starting from that group's carry-in.
  always_comb begin
    logic grp_g;
    logic grp_p;
    logic ci;
    g     = a & b;
    p     = a ^ b;
    cg    = '0;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    ci    = 1'b0;
    for (int k = 0; k < NG - 1; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j < 4; j++) begin
        grp_g = g[k*4+j] | (p[k*4+j] & grp_g);
        grp_p = grp_p & p[k*4+j];
      end
      cg[k+1] = grp_g | (grp_p & cg[k]);
    end
    for (int i = 0; i < W; i++) begin
      ci = cg[i/4];
      for (int j = (i / 4) * 4; j < i; j++) begin
        ci = g[j] | (p[j] & ci);
      end
      c[i] = ci;
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/booth_step.sv
// One combinational Booth step: recodes {Q[0],Q[-1]}, adds the selected
// multiple of M into the upper half of {A,Q} and arithmetic-shifts right by one.
module booth_step
  import booth_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic         q_m1,
  input  logic [N:0]   m_ext,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next,
  output logic         q_m1_next
);

  localparam int W = acc_width(N);

  op_t          op;
  logic [N:0]   addend;
  logic [W-1:0] sum;

  always_comb begin
    op = OP_NONE;
    case ({q[0], q_m1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    addend = '0;
    case (op)
      OP_ADD:  addend = m_ext;
      OP_SUB:  addend = ~m_ext + 1'b1;
      default: addend = '0;
    endcase
  end

  booth_cla_adder #(.W(W)) u_adder (
    .a   ({a, q}),
    .b   ({addend, {N{1'b0}}}),
    .sum (sum)
  );

  // The old Q[-1] falls off the bottom; the sum MSB is replicated at the top.
  assign {a_next, q_next, q_m1_next} = {sum[W-1], sum};

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth signed multiplier, N-bit operands, 2N-bit product.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand jumps straight to DONE.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        next_state;
  logic [N:0]    a;
  logic [N:0]    a_next;
  logic [N:0]    m_reg;
  logic [N-1:0]  q;
  logic [N-1:0]  q_next;
  logic          q_m1;
  logic          q_m1_next;
  logic [CW-1:0] count;
  logic          zero_op;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  booth_step #(.N(N)) u_step (
    .a         (a),
    .q         (q),
    .q_m1      (q_m1),
    .m_ext     (m_reg),
    .a_next    (a_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = zero_op ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (count == LAST) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The product register is loaded on the final step so it is already valid
  // in the DONE cycle, and then holds until a later result replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a     <= '0;
          q     <= multiplier;
          q_m1  <= 1'b0;
          m_reg <= {multiplicand[N-1], multiplicand};
          count <= '0;
          if (zero_op) product <= '0;
        end
        RUN: begin
          a     <= a_next;
          q     <= q_next;
          q_m1  <= q_m1_next;
          count <= count + 1'b1;
          if (count == LAST) product <= {a_next[N-1:0], q_next};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Iterative radix-2 Booth signed multiplier. Multiplies two N-bit two's-complement operands into a 2N-bit product.
- Holds the {A,Q} accumulator and the Q[-1] flop, and runs the Booth recode/step sequence.
- Each cycle it produces the (2N+1)-bit add/subtract operand pair consumed by the downstream carry-lookahead accumulator adder (13 bits at the default N=6).
- Sits between operand registers and the product consumer in the Booth datapath.

Parameters:
- N, 6, operand width. Accumulator {A,Q} width = 2N+1, product width = 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  N  signed M, captured on accepted start
- multiplier  input  N  signed Q, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when the product is valid
- product  output  2N  signed result; held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, product=0, state=IDLE, A=0, Q=0, Q[-1]=0, step count=0.
- Registers:
  - A is N+1 bits; M is sign-extended to N+1 bits so that negating the most negative M cannot overflow.
  - Q is N bits; Q[-1] is 1 bit.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - If start=1: load A=0, Q=multiplier, Q[-1]=0, Mreg=sext(multiplicand), count=0, then go to RUN.
  - If start=0: stay in IDLE; product is held.
- RUN, each cycle:
  - Recode {Q[0],Q[-1]}: 01 -> add +M; 10 -> add -M (~Mext+1, N+1 bits); 00/11 -> add 0.
  - Sum = {A,Q} + {addend, N'b0}, computed in 2N+1 bits with carry-in 0; the carry out of the MSB is discarded.
  - Arithmetic right shift of {Sum,Q[-1]} by 1: the new A MSB replicates the Sum MSB, and the new Q[-1] is the old Sum bit 0.
  - count increments; after the N-th step (count==N-1) go to DONE.
- DONE: product = {A[N-1:0],Q}; done=1 for exactly this cycle; go to IDLE next cycle.
- Latency: start accepted at edge t -> done high in cycle t+N+1 (7 cycles at N=6). Throughput is one result per N+2 cycles.
- start while busy=1 is ignored; operand inputs are don't-care outside an accepted start.
- start in the same cycle as done is ignored. A new start is accepted on the following IDLE cycle.
- rst asserted mid-RUN or in DONE: next cycle everything returns to the reset values, the product clears to 0, and no done pulse is issued.
- rst takes priority over start in the same cycle.
- Corner operands: -2^(N-1) x -2^(N-1) = +2^(2N-2) (1024 at N=6) is exact; every product fits in 2N bits, with no overflow flag.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: if the captured multiplicand==0 or multiplier==0 at start, the FSM goes IDLE -> DONE directly, with product 0 and done at t+1.
- Undefined: every operation takes the full N RUN cycles regardless of operand values.
- The result value is identical in both builds; only latency differs.

Decomposition:
- Shared package booth_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - recode constants (OP_NONE, OP_ADD, OP_SUB);
  - width helper constant ACC_W=2N+1.
- One natural sub-module, booth_step (combinational): takes {A,Q,Q[-1]} and Mext; returns the addend-select, sum and shifted next state. It instantiates the team's accumulator carry-lookahead adder for the 2N+1-bit add.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then start with M=3, Q=5 -> busy high, done pulses exactly 7 cycles after start, product=15.
- M=-7, Q=13 -> product=-91 (12'hFA5); M=13, Q=-7 gives the same value.
- M=-32, Q=-32 -> product=1024 (12'h400). M=-32, Q=31 -> product=-992 (12'hC20).
- Start asserted again during RUN with M=1, Q=1 -> ignored; the first result completes unchanged. A start one cycle after done is accepted and yields 1.
- rst pulsed in the 3rd RUN cycle of 21x-11 -> next cycle busy=0, product=0, no done pulse. A fresh start then gives -231.
- With BOOTH_ZERO_SKIP_EN: M=0, Q=-17 -> done at start+1, product=0. Without the macro: the same stimulus gives done at start+7, product=0.
